data_mem_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory interface. Accepts one load/store request at a time

---
 rtl/data_mem_responder_if.sv | 18 +
 rtl/data_mem_responder.sv | 112 +++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// CPU data-memory request/response bundle.
// The CPU side uses the master modport and the memory side uses the slave modport.
interface data_mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              err;

    modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, busy, err);
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data-memory port.
// It accepts one load/store at a time and waits WAIT_CYCLES before committing.
// It then answers with a single-cycle registered ack.
// Optional feature macro: ADDR_CHECK_EN. When it is defined, an address >= DEPTH
// raises err, suppresses the store and returns zero on a load.
module data_mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = DEPTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              commit;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              ack_q, err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // With zero wait states the commit happens on the capture edge itself,
    // so the operation is taken straight from the bus while idle.
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [IDX_W-1:0]  c_idx;
    logic              addr_bad;

    assign c_we    = (state == S_IDLE) ? bus.we    : op_we;
    assign c_addr  = (state == S_IDLE) ? bus.addr  : op_addr;
    assign c_wdata = (state == S_IDLE) ? bus.wdata : op_wdata;
    assign c_idx   = c_addr[IDX_W-1:0];

`ifdef ADDR_CHECK_EN
    assign addr_bad = (32'(c_addr) >= DEPTH_U);
`else
    assign addr_bad = 1'b0;
`endif

    // Next-state and commit decode for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_IDLE: if (bus.req) begin
                cnt_nxt = 4'(WAIT_CYCLES);
                if (WAIT_CYCLES == 0) begin
                    state_nxt = S_RESP;
                    commit    = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = S_RESP;
                    commit    = 1'b1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registers for the state, the latched operation and the response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack_q <= commit;
            if (state == S_IDLE && bus.req) begin
                op_we    <= bus.we;
                op_addr  <= bus.addr;
                op_wdata <= bus.wdata;
            end
            if (commit) begin
                err_q <= addr_bad;
                if (!c_we)
                    rdata_q <= addr_bad ? '0 : mem[c_idx];
            end
        end
    end

    // Array write. A reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_we && !addr_bad)
            mem[c_idx] <= c_wdata;
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state != S_IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH=128, WAIT_CYCLES=2).
// A timeline model predicts ack/busy/rdata/err, and a checker compares them every cycle.
// Hand-computed literal checks pin the latency and the data values.
module tb_data_mem_responder;
    localparam int W     = 2;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    data_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit model_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model. An accepted request at edge e is answered on edge e+W,
    // and the next request can be accepted at edge e+W+2.
    int         e = 0;
    int         cap_e = 0;
    bit         pend = 0;
    bit         m_we;
    logic [7:0] m_addr, m_wd;
    logic [7:0] mmem [DEPTH];
    bit         mknown [DEPTH];
    bit         x_ack = 0, x_busy = 0, x_err = 0, x_rknown = 1;
    logic [7:0] x_rdata = 0;

    always @(posedge clk) begin
        bit bad;
        int i;
        e++;
        if (rst) begin
            pend = 0; x_ack = 0; x_busy = 0; x_err = 0; x_rdata = 0; x_rknown = 1;
        end else begin
            x_ack = 0;
            if (pend && e == cap_e + W + 1) pend = 0;
            else if (!pend && bus.req) begin
                pend = 1; cap_e = e; m_we = bus.we; m_addr = bus.addr; m_wd = bus.wdata;
            end
            if (pend && e == cap_e + W) begin
                x_ack = 1;
`ifdef ADDR_CHECK_EN
                bad = (int'(m_addr) >= DEPTH);
`else
                bad = 0;
`endif
                i = int'(m_addr) % DEPTH;
                x_err = bad;
                if (m_we) begin
                    if (!bad) begin mmem[i] = m_wd; mknown[i] = 1; end
                end else if (bad) begin
                    x_rdata = 0; x_rknown = 1;
                end else begin
                    x_rdata = mmem[i]; x_rknown = mknown[i];
                end
            end
            x_busy = pend;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("ack", bus.ack, x_ack);
            chk("busy", bus.busy, x_busy);
            chk("err", bus.err, x_err);
            if (x_rknown) chk("rdata", bus.rdata, x_rdata);
        end
    end

    // Issue one request, hold req until ack and drop it on that cycle.
    // lat counts cycles from req assertion to the ack cycle.
    task automatic op(input bit w, input logic [7:0] a, input logic [7:0] d,
                      output int lat, output logic [7:0] rd, output logic er);
        bus.req = 1; bus.we = w; bus.addr = a; bus.wdata = d;
        lat = 0; rd = 'x; er = 'x;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (bus.ack) begin rd = bus.rdata; er = bus.err; break; end
        end
        if (rd === 'x && er === 'x) begin
            n_vec++; n_bad++;
            $display("FAIL ack_timeout: no ack for addr %0h within 20 cycles", a);
        end
        bus.req = 0;
    endtask

    int         lat;
    logic [7:0] rd;
    logic       er;
    int         t1, t2;

    initial begin
        bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
        @(negedge clk);
        model_on = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata", bus.rdata, 0);

        // Reset during WAIT must discard the store.
        op(1, 8'h20, 8'h77, lat, rd, er);
        op(1, 8'h21, 8'h55, lat, rd, er);
        @(negedge clk);
        bus.req = 1; bus.we = 1; bus.addr = 8'h20; bus.wdata = 8'h99;
        @(negedge clk);
        bus.req = 0; rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        chk("midrst_ack", bus.ack, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rdata", bus.rdata, 0);
        chk("midrst_err", bus.err, 0);
        op(0, 8'h20, 8'h00, lat, rd, er);
        chk("midrst_reload", rd, 8'h77);

        // Reset on the edge that would enter RESP must also discard the store.
        @(negedge clk);
        bus.req = 1; bus.we = 1; bus.addr = 8'h21; bus.wdata = 8'hEE;
        @(negedge clk);
        bus.req = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("resprst_ack", bus.ack, 0);
        op(0, 8'h21, 8'h00, lat, rd, er);
        chk("resprst_reload", rd, 8'h55);

        // Check store latency and ack width, then load the stored value back.
        @(negedge clk);
        op(1, 8'h10, 8'hA5, lat, rd, er);
        chk("store_latency", lat, W + 1);
        @(negedge clk);
        chk("ack_width", bus.ack, 0);
        op(0, 8'h10, 8'h00, lat, rd, er);
        chk("load_A5", rd, 8'hA5);
        chk("load_latency", lat, W + 1);

        // A store must leave rdata unchanged.
        @(negedge clk);
        op(0, 8'h10, 8'h00, lat, rd, er);
        @(negedge clk);
        op(1, 8'h10, 8'h3C, lat, rd, er);
        chk("store_keeps_rdata", rd, 8'hA5);
        @(negedge clk);
        chk("after_store_rdata", bus.rdata, 8'hA5);
        op(0, 8'h10, 8'h00, lat, rd, er);
        chk("load_3C", rd, 8'h3C);

        // Holding req after ack starts a new request.
        @(negedge clk);
        bus.req = 1; bus.we = 1; bus.addr = 8'h30; bus.wdata = 8'h11;
        t1 = -1; t2 = -1;
        for (int k = 0; k < 20 && t2 < 0; k++) begin
            @(negedge clk);
            if (bus.ack) begin
                if (t1 < 0) begin t1 = k; bus.addr = 8'h31; bus.wdata = 8'h22; end
                else t2 = k;
            end
        end
        bus.req = 0;
        chk("ack_period", t2 - t1, W + 2);
        @(negedge clk);
        op(0, 8'h30, 8'h00, lat, rd, er);
        chk("held_first", rd, 8'h11);
        @(negedge clk);
        op(0, 8'h31, 8'h00, lat, rd, er);
        chk("held_second", rd, 8'h22);

        // Changing inputs during WAIT must not affect the latched operation.
        @(negedge clk);
        op(1, 8'h41, 8'h00, lat, rd, er);
        @(negedge clk);
        bus.req = 1; bus.we = 1; bus.addr = 8'h40; bus.wdata = 8'hAB;
        @(negedge clk);
        bus.we = 0; bus.addr = 8'h41; bus.wdata = 8'hCD;
        for (int k = 0; k < 20 && !bus.ack; k++) @(negedge clk);
        bus.req = 0;
        @(negedge clk);
        op(0, 8'h40, 8'h00, lat, rd, er);
        chk("latched_store", rd, 8'hAB);
        @(negedge clk);
        op(0, 8'h41, 8'h00, lat, rd, er);
        chk("untouched_addr", rd, 8'h00);

        // Access to an address beyond DEPTH.
        @(negedge clk);
        op(1, 8'h90, 8'h5A, lat, rd, er);
`ifdef ADDR_CHECK_EN
        chk("oob_store_err", er, 1);
        @(negedge clk);
        op(0, 8'h90, 8'h00, lat, rd, er);
        chk("oob_load_err", er, 1);
        chk("oob_load_zero", rd, 8'h00);
        @(negedge clk);
        op(0, 8'h10, 8'h00, lat, rd, er);
        chk("oob_no_alias", rd, 8'h3C);
        chk("err_cleared", er, 0);
`else
        chk("wrap_store_err", er, 0);
        @(negedge clk);
        op(0, 8'h10, 8'h00, lat, rd, er);
        chk("wrap_alias", rd, 8'h5A);
        chk("wrap_err", er, 0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
